// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the unified-memory port arbiter:
//   - state_t     : sequencer states ST_IDLE, ST_ACCESS, ST_RESP
//   - GNT_IF/GNT_D: encoding of the grant bit (which requester owns the access)
//   - WAIT_W      : width of the wait-state counter (supports 0..15 wait states)
//   - CNT_ZERO/CNT_ONE : counter comparison constants
package mem_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam logic [WAIT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [WAIT_W-1:0] CNT_ONE  = 4'd1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational winner selection between the instruction-fetch and data ports.
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round robin; on a tie the requester not granted last wins
//   undefined : fixed priority; the data port always beats instruction fetch
// Ports:
//   i_if_req     - instruction fetch request
//   i_d_req      - data request
//   i_last_grant - most recent winner (GNT_IF/GNT_D), only used in round robin
//   o_grant      - selected winner (GNT_IF/GNT_D); meaningful only when a req is high
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_last_grant,
  output logic o_grant
);

`ifdef MEM_ARB_RR_EN
  // Tie goes to whichever port was not served last; a lone requester wins outright.
  always_comb begin
    o_grant = GNT_IF;
    if (i_if_req && i_d_req) begin
      o_grant = (i_last_grant == GNT_IF) ? GNT_D : GNT_IF;
    end else if (i_d_req) begin
      o_grant = GNT_D;
    end else begin
      o_grant = GNT_IF;
    end
  end
`else
  // Fixed priority has no history, so the last-grant input is deliberately ignored.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;

  // Data port first, instruction fetch otherwise.
  always_comb begin
    o_grant = GNT_IF;
    if (i_d_req) begin
      o_grant = GNT_D;
    end else if (i_if_req) begin
      o_grant = GNT_IF;
    end else begin
      o_grant = GNT_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified instruction/data memory between the instruction-fetch
// port (IF) and the load/store port (D). A winner is latched in IDLE, the
// memory is driven for WAIT_CYCLES+1 ACCESS cycles, then a one-cycle ack is
// returned in RESP together with a registered read word.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration; default is
// fixed priority with D over IF).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   if_req/if_addr       - fetch request and byte address; if_ack/if_rdata response
//   d_req/d_we/d_addr/d_wdata - data request; d_ack/d_rdata response
//   mem_addr/mem_wdata/mem_read/mem_write - memory controls (registered)
//   mem_rdata            - combinational read data from the memory
//   busy                 - high whenever the sequencer is not in IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_CYCLES[WAIT_W-1:0];

  state_t            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ack;
  logic              r_d_ack;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_busy;

  logic              w_any_req;
  logic              w_grant;
  logic              w_grant_we;
  logic              w_last_grant;

  assign w_any_req  = if_req | d_req;
  assign w_grant_we = (w_grant == GNT_D) & d_we;

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;

  // Remember every winner so the next tie goes to the other port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GNT_IF;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_last_grant <= w_grant;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = GNT_IF;
`endif

  mem_arb_pick u_pick (
    .i_if_req     (if_req),
    .i_d_req      (d_req),
    .i_last_grant (w_last_grant),
    .o_grant      (w_grant)
  );

  // Sequencer: latch the winner in IDLE, drive memory in ACCESS, ack in RESP.
  // Memory controls are computed one cycle ahead so they are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_grant     <= GNT_IF;
      r_we        <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_if_rdata  <= {DATA_W{1'b0}};
      r_d_rdata   <= {DATA_W{1'b0}};
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state     <= ST_ACCESS;
            r_busy      <= 1'b1;
            r_grant     <= w_grant;
            r_we        <= w_grant_we;
            r_addr      <= (w_grant == GNT_D) ? d_addr : if_addr;
            r_wdata     <= d_wdata;
            r_cnt       <= WAIT_INIT;
            r_mem_read  <= ~w_grant_we;
            // With no wait states the single ACCESS cycle is also the write cycle.
            r_mem_write <= w_grant_we & (WAIT_INIT == CNT_ZERO);
          end else begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == CNT_ZERO) begin
            r_state     <= ST_RESP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_grant == GNT_IF) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= mem_rdata;
            end else begin
              r_d_ack <= 1'b1;
              // Stores leave the load result register untouched.
              if (!r_we) begin
                r_d_rdata <= mem_rdata;
              end else begin
                r_d_rdata <= r_d_rdata;
              end
            end
          end else begin
            r_cnt       <= r_cnt - CNT_ONE;
            // Assert write only for the last ACCESS cycle (counter reaching zero).
            r_mem_write <= r_we & (r_cnt == CNT_ONE);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Three arbiter instances with WAIT_CYCLES = 0, 3 and 2, each attached to its
// own behavioural 256-word memory (word index = address bits [9:2]).
// Honours MEM_ARB_RR_EN to select the expected arbitration rule.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        mem_init;
  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic        if_ack    [3];
  logic [31:0] if_rdata  [3];
  logic        d_req     [3];
  logic        d_we      [3];
  logic [31:0] d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic        d_ack     [3];
  logic [31:0] d_rdata   [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [31:0] mem_rdata [3];
  logic        busy      [3];
  logic [31:0] mem       [3][256];

  int errs;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_read(mem_read[g]),
      .mem_write(mem_write[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
    assign mem_rdata[g] = mem[g][mem_addr[g][9:2]];
  end

  // Behavioural memories: word 0 holds 0x20040005, the rest start at zero.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mem_init) begin
        for (int j = 0; j < 256; j++) mem[i][j] <= (j == 0) ? 32'h2004_0005 : 32'h0;
      end else if (mem_write[i]) begin
        mem[i][mem_addr[i][9:2]] <= mem_wdata[i];
      end
    end
  end

  function automatic int wc(input int u);
    if (u == 0) return 0;
    else if (u == 1) return 3;
    else return 2;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      if_req[i] = 1'b0; if_addr[i] = 32'h0; d_req[i] = 1'b0; d_we[i] = 1'b0;
      d_addr[i] = 32'h0; d_wdata[i] = 32'h0;
    end
  endtask

  // One complete request on instance u; returns latency and per-signal cycle counts.
  task automatic do_access(input int u, input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output int n_rd, output int n_wr,
                           output int n_busy, output int n_other, output logic ack_after);
    lat = -1; n_rd = 0; n_wr = 0; n_busy = 0; n_other = 0;
    if (is_d) begin
      d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = addr; d_wdata[u] = wd;
    end else begin
      if_req[u] = 1'b1; if_addr[u] = addr;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_read[u]) n_rd++;
      if (mem_write[u]) n_wr++;
      if (busy[u]) n_busy++;
      if (is_d ? if_ack[u] : d_ack[u]) n_other++;
      if (is_d ? d_ack[u] : if_ack[u]) begin
        lat = k;
        break;
      end
    end
    if_req[u] = 1'b0; d_req[u] = 1'b0; d_we[u] = 1'b0;
    @(negedge clk);
    ack_after = if_ack[u] | d_ack[u];
  endtask

  task automatic test_reset();
    logic [4:0] ctl;
    clear_inputs();
    reset = 1'b1; mem_init = 1'b1;
    @(negedge clk); @(negedge clk);
    mem_init = 1'b0;
    for (int u = 0; u < 3; u++) begin
      ctl = {if_ack[u], d_ack[u], mem_read[u], mem_write[u], busy[u]};
      checks++;
      if (ctl !== 5'b0) begin
        errs++; $display("FAIL reset_ctl[%0d]: got %b want 00000", u, ctl);
      end
      checks++;
      if ({if_rdata[u], d_rdata[u], mem_addr[u], mem_wdata[u]} !== 128'h0) begin
        errs++;
        $display("FAIL reset_data[%0d]: got %h %h %h %h want all zero", u, if_rdata[u], d_rdata[u],
                 mem_addr[u], mem_wdata[u]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errs++; $display("FAIL idle_after_reset: busy got %b want 0", busy[0]);
    end
  endtask

  // Both ports request continuously on instance 0 (no wait states) for four grants.
  task automatic test_arbitration();
    int got, lat, want;
    if_req[0] = 1'b1; if_addr[0] = 32'h4;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h8;
    for (int r = 0; r < 4; r++) begin
      got = -1; lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (if_ack[0] || d_ack[0]) begin
          lat = k;
          got = (if_ack[0] && d_ack[0]) ? 2 : (d_ack[0] ? 1 : 0);
          break;
        end
      end
      want = (RR && (r % 2 == 1)) ? 0 : 1;
      checks++;
      if (got !== want) begin
        errs++; $display("FAIL arb_winner round %0d: got %0d want %0d (1=D 0=IF)", r, got, want);
      end
      checks++;
      if (lat !== ((r == 0) ? 2 : 3)) begin
        errs++; $display("FAIL arb_spacing round %0d: got %0d want %0d", r, lat, (r == 0) ? 2 : 3);
      end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    int lat, n_rd, n_wr, n_busy, n_other;
    logic ack_after;
    do_access(0, 1'b0, 1'b0, 32'h0, 32'h0, lat, n_rd, n_wr, n_busy, n_other, ack_after);
    checks++;
    if (lat !== 2) begin errs++; $display("FAIL if_latency: got %0d want 2", lat); end
    checks++;
    if (if_rdata[0] !== 32'h2004_0005) begin
      errs++; $display("FAIL if_rdata: got %h want 20040005", if_rdata[0]);
    end
    checks++;
    if ({n_rd, n_wr, n_other} !== {32'd1, 32'd0, 32'd0} || ack_after !== 1'b0) begin
      errs++; $display("FAIL if_ctl: rd=%0d wr=%0d other_ack=%0d ack_after=%b want 1 0 0 0",
                       n_rd, n_wr, n_other, ack_after);
    end
  endtask

  task automatic test_store_load();
    int lat, n_rd, n_wr, n_busy, n_other;
    logic ack_after;
    do_access(0, 1'b1, 1'b1, 32'h80, 32'h1234_5678, lat, n_rd, n_wr, n_busy, n_other, ack_after);
    checks++;
    if ({lat, n_wr, n_rd} !== {32'd2, 32'd1, 32'd0}) begin
      errs++; $display("FAIL store_ctl: lat=%0d wr=%0d rd=%0d want 2 1 0", lat, n_wr, n_rd);
    end
    checks++;
    if (d_rdata[0] !== 32'h0) begin
      errs++; $display("FAIL store_no_rdata: got %h want 00000000", d_rdata[0]);
    end
    do_access(0, 1'b1, 1'b0, 32'h80, 32'h0, lat, n_rd, n_wr, n_busy, n_other, ack_after);
    checks++;
    if (d_rdata[0] !== 32'h1234_5678) begin
      errs++; $display("FAIL load_rdata: got %h want 12345678", d_rdata[0]);
    end
    checks++;
    if (if_rdata[0] !== 32'h2004_0005 || n_wr !== 0) begin
      errs++; $display("FAIL load_side: if_rdata=%h wr=%0d want 20040005 0", if_rdata[0], n_wr);
    end
  endtask

  task automatic test_wait_states();
    int lat, n_rd, n_wr, n_busy, n_other;
    logic ack_after;
    do_access(1, 1'b0, 1'b0, 32'h0, 32'h0, lat, n_rd, n_wr, n_busy, n_other, ack_after);
    checks++;
    if ({lat, n_rd, n_busy} !== {32'd5, 32'd4, 32'd5}) begin
      errs++; $display("FAIL wait3: lat=%0d rd=%0d busy=%0d want 5 4 5", lat, n_rd, n_busy);
    end
    checks++;
    if (if_rdata[1] !== 32'h2004_0005) begin
      errs++; $display("FAIL wait3_rdata: got %h want 20040005", if_rdata[1]);
    end
  endtask

  task automatic test_addr_change();
    int lat;
    lat = -1;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h40; d_wdata[1] = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (d_ack[1]) begin
        lat = k;
        break;
      end
      checks++;
      if (mem_addr[1] !== 32'h40 || mem_write[1] !== 1'b0) begin
        errs++; $display("FAIL addr_hold cyc %0d: addr=%h wr=%b want 00000040 0", k, mem_addr[1],
                         mem_write[1]);
      end
      d_addr[1] = 32'h3FC; d_we[1] = 1'b1; d_wdata[1] = 32'hFFFF_FFFF;
    end
    checks++;
    if (lat !== 5) begin errs++; $display("FAIL addr_change_lat: got %0d want 5", lat); end
    d_req[1] = 1'b0; d_we[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int lat, n_rd, n_wr, n_busy, n_other, n_bad;
    logic ack_after;
    d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 32'h100; d_wdata[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (busy[2] !== 1'b1 || mem_write[2] !== 1'b0) begin
      errs++; $display("FAIL rst_mid_access: busy=%b wr=%b want 1 0", busy[2], mem_write[2]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; d_req[2] = 1'b0; d_we[2] = 1'b0;
    checks++;
    if ({busy[2], mem_write[2], mem_read[2], d_ack[2]} !== 4'b0) begin
      errs++; $display("FAIL rst_mid_idle: got %b want 0000",
                       {busy[2], mem_write[2], mem_read[2], d_ack[2]});
    end
    n_bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_write[2] || d_ack[2] || busy[2]) n_bad++;
    end
    checks++;
    if (n_bad !== 0) begin errs++; $display("FAIL rst_mid_quiet: got %0d want 0", n_bad); end
    do_access(2, 1'b1, 1'b0, 32'h100, 32'h0, lat, n_rd, n_wr, n_busy, n_other, ack_after);
    checks++;
    if (d_rdata[2] !== 32'h0 || lat !== 4) begin
      errs++; $display("FAIL rst_mid_old: rdata=%h lat=%0d want 00000000 4", d_rdata[2], lat);
    end
  endtask

  // Random traffic against a transaction-level model of grants, timing and memory.
  task automatic test_random(input int u, input int ncyc);
    logic [31:0] mm [256];
    bit          ip, dp, dwe, act, win, lwe, last_g, e_busy, e_acc;
    logic [31:0] ia, da, dwd, laddr, lwd, edat, tmp;
    int          w, gk, ak, nidle;
    logic [4:0]  exp_v, got_v;
    w = wc(u);
    for (int j = 0; j < 256; j++) mm[j] = (j == 0) ? 32'h2004_0005 : 32'h0;
    ip = 1'b0; dp = 1'b0; dwe = 1'b0; act = 1'b0; win = 1'b0; lwe = 1'b0; last_g = 1'b0;
    ia = 32'h0; da = 32'h0; dwd = 32'h0; laddr = 32'h0; lwd = 32'h0; edat = 32'h0;
    gk = 0; ak = 0; nidle = 0;
    clear_inputs();
    reset = 1'b1; mem_init = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    for (int k = 0; k < ncyc + 24; k++) begin
      e_busy = act && (k > gk) && (k <= ak);
      e_acc  = act && (k > gk) && (k < ak);
      exp_v  = {e_busy, e_acc && !lwe, e_acc && lwe && (k == ak - 1),
                act && (k == ak) && !win, act && (k == ak) && win};
      got_v  = {busy[u], mem_read[u], mem_write[u], if_ack[u], d_ack[u]};
      checks++;
      if (got_v !== exp_v) begin
        errs++; $display("FAIL rnd%0d cyc %0d busy/rd/wr/ifack/dack: got %b want %b", u, k, got_v, exp_v);
      end
      if (e_acc) begin
        checks++;
        if (mem_addr[u] !== laddr || (lwe && mem_wdata[u] !== lwd)) begin
          errs++; $display("FAIL rnd%0d cyc %0d mem_bus: got %h/%h want %h/%h", u, k, mem_addr[u],
                           mem_wdata[u], laddr, lwd);
        end
      end
      if (act && (k == ak)) begin
        if (!lwe) begin
          tmp = win ? d_rdata[u] : if_rdata[u];
          checks++;
          if (tmp !== edat) begin
            errs++; $display("FAIL rnd%0d cyc %0d rdata(port %0d): got %h want %h", u, k, win, tmp, edat);
          end
        end
        if (win) dp = 1'b0; else ip = 1'b0;
        act = 1'b0;
      end
      if (k < ncyc) begin
        if (!ip && $urandom_range(0, 2) == 0) begin
          ip = 1'b1;
          ia = ($urandom() & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2);
        end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp  = 1'b1;
          da  = ($urandom() & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2);
          dwe = ($urandom_range(0, 1) == 1);
          dwd = $urandom();
        end
      end
      if_req[u] = ip; if_addr[u] = ia;
      d_req[u] = dp; d_addr[u] = da; d_we[u] = dwe; d_wdata[u] = dwd;
      if (!act && (k >= nidle) && (ip || dp)) begin
        if (ip && dp) win = RR ? !last_g : 1'b1;
        else win = dp;
        last_g = win; act = 1'b1; gk = k; ak = k + 2 + w; nidle = ak + 1;
        laddr = win ? da : ia; lwe = win && dwe; lwd = dwd;
        if (lwe) mm[laddr[9:2]] = lwd;
        else edat = mm[laddr[9:2]];
      end
      @(negedge clk);
    end
  endtask

  initial begin
    errs = 0; checks = 0;
    reset = 1'b1; mem_init = 1'b1;
    clear_inputs();
    test_reset();
    test_arbitration();
    test_if_read();
    test_store_load();
    test_wait_states();
    test_addr_change();
    test_reset_mid_access();
    for (int u = 0; u < 3; u++) test_random(u, 250);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single unified instruction/data memory of the multi-cycle processor between two requesters: the instruction-fetch port (IF) and the load/store data port (D). Each requester uses a req/ack handshake. The arbiter chooses one winner and latches its address, write data and direction. It then drives the memory's address, write-data, read and write controls for a configurable number of cycles and returns a registered read word with a one-cycle ack. It sits between the control unit/datapath and the memory instance.

## Interface
- ADDR_W, 32, address width passed to memory unchanged
- DATA_W, 32, data word width
- WAIT_CYCLES, 0, extra memory wait states per access (0..15)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  instruction fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch byte address
- if_ack  out  1  one-cycle completion pulse for IF
- if_rdata  out  DATA_W  fetched word, valid from if_ack cycle until next IF completion
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse for D
- d_rdata  out  DATA_W  load word, valid from d_ack cycle until next D load completion
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  DATA_W  from memory Mem_data (combinational read)
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick the winner (see Configuration), latch addr/wdata/we/grant, load wait counter = WAIT_CYCLES, go ACCESS. Otherwise stay.
- ACCESS: mem_addr/mem_wdata come from the latched registers.
  - Read: mem_read = 1 for all ACCESS cycles.
  - Write: mem_read = 0. mem_write = 1 only in the final ACCESS cycle (counter == 0), so exactly one memory write occurs.
  - When counter == 0: capture mem_rdata into the winner's rdata register (reads only) and go RESP. Otherwise decrement the counter.
- RESP: the winner's ack = 1 for exactly this cycle, all mem controls = 0, go IDLE.
- Requesters drop req in the cycle after they observe ack. A req still high in IDLE is treated as a new request.
- Inputs are only sampled in IDLE. Changes to addr/wdata/we during ACCESS are ignored.
- d_rdata is not updated by stores. if_rdata and d_rdata are independent registers.
- Addresses pass through unmodified. There is no alignment check, and the memory uses bits [9:2].

## Timing
- Reset values: state IDLE, if_ack 0, d_ack 0, if_rdata 0, d_rdata 0, mem_addr 0, mem_wdata 0, mem_read 0, mem_write 0, busy 0, wait counter 0.
- Latency: req high in IDLE cycle t, ACCESS during t+1..t+1+WAIT_CYCLES, ack in cycle t+2+WAIT_CYCLES. The minimum is 2 cycles from req to ack.
- Throughput: one access per WAIT_CYCLES+3 cycles, because of one IDLE cycle between grants.
- Both requests high in IDLE: exactly one is granted. The loser stays pending and is granted on the next IDLE.
- Reset asserted in any cycle: next state is IDLE, no ack is issued, and the latched request is discarded.
  - If reset coincides with the final ACCESS cycle of a write, the memory write at that edge still occurs, since mem_write is already asserted. Reset sampled earlier in ACCESS prevents the write.
- No combinational path from req to ack or to mem outputs. mem_* outputs depend only on state and latched registers.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A last_grant register is updated on every grant.
  - On a tie, the requester not granted last wins.
  - last_grant resets to IF, so the first tie goes to D.
- MEM_ARB_RR_EN undefined: fixed priority, D always beats IF. No last_grant register exists.
- With a single requester, both modes grant it immediately.

## Structure
- Package mem_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_ACCESS, ST_RESP
  - grant encoding GNT_IF = 0, GNT_D = 1
  - WAIT counter width constant (4)
- Sub-module mem_arb_pick: combinational winner selection from if_req, d_req and last_grant. Its output is the grant bit. Its body contains the MEM_ARB_RR_EN conditional.

## Test plan
- Reset, then IF read of 0x00000000 with WAIT_CYCLES=0 → ack 2 cycles after req; if_rdata = 0x20040005.
- D store 0x12345678 to 0x00000080, then D load of 0x00000080 → mem_write high for exactly one cycle; d_rdata = 0x12345678; if_rdata unchanged.
- if_req and d_req rise together, repeated 4 times:
  - fixed: D, D, D, D grants while D keeps requesting.
  - with MEM_ARB_RR_EN: D, IF, D, IF.
- WAIT_CYCLES=3, IF read → mem_read high 4 cycles, ack 5 cycles after req; busy high 5 cycles.
- D store with WAIT_CYCLES=2, reset pulsed in the first ACCESS cycle → no mem_write, no d_ack, state IDLE next cycle; a subsequent load of that address returns the old value 0x00000000.
- Requester changes d_addr mid-ACCESS → mem_addr holds the originally latched address until RESP.
